// File: rtl/interfaz_tx.sv
// interfaz_tx: captures an ALU result and feeds it byte by byte (MSB first) into the UART tx core.
// Latency: start to tx one cycle after i_alu_done; each further byte one cycle after the previous i_tx_done.
// Backpressure: paced only by i_tx_done; results arriving while busy are dropped and flagged in o_overrun.
// Optional: define INTERFAZ_TX_HEADER_EN to prefix every result with the HEADER sync byte.
module interfaz_tx #(
  parameter int              DBIT      = 8,
  parameter int              NB_RESULT = 8,
  parameter logic [DBIT-1:0] HEADER    = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_alu_done,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [DBIT-1:0]      o_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun
);

  localparam int N_BYTES = NB_RESULT / DBIT;
  // The counter must also hold N_BYTES when the header adds one extra frame.
  localparam int CW = $clog2(N_BYTES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NB_RESULT-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;
  logic                 hdr_phase;

`ifdef INTERFAZ_TX_HEADER_EN
  logic hdr_q, hdr_d;
  assign hdr_phase = hdr_q;

  // Header phase flag: set on accept, cleared once the header frame has been acknowledged.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hdr_q <= 1'b0;
    end else begin
      hdr_q <= hdr_d;
    end
  end

  // Header flag next state mirrors the main FSM's accept / header-ack events.
  always_comb begin
    hdr_d = hdr_q;
    if (state_q == ST_WAIT && i_tx_done && hdr_q) begin
      hdr_d = 1'b0;
    end
    if (accept) begin
      hdr_d = 1'b1;
    end
  end
`else
  assign hdr_phase = 1'b0;
`endif

  // Next-state logic: FSM sequencing, byte shifting, done pulse and sticky overrun.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_alu_done) begin
          accept = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        if (i_alu_done) begin
          ovr_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (cnt_q != '0) begin
            // The header frame does not consume result bits, so skip the shift.
            if (!hdr_phase) begin
              shift_d = shift_q << DBIT;
            end
            cnt_d   = cnt_q - CW'(1);
            state_d = ST_START;
            if (i_alu_done) begin
              ovr_d = 1'b1;
            end
          end else begin
            // Last byte acknowledged; a coincident new result chains straight into START.
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (i_alu_done) begin
              accept = 1'b1;
            end
          end
        end else if (i_alu_done) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept) begin
      shift_d = i_result;
`ifdef INTERFAZ_TX_HEADER_EN
      cnt_d   = CW'(N_BYTES);
`else
      cnt_d   = CW'(N_BYTES - 1);
`endif
      state_d = ST_START;
    end
  end

  // State registers with synchronous active-low reset; reset aborts any transfer in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign o_tx_start = (state_q == ST_START);
  assign o_data     = hdr_phase ? HEADER : shift_q[NB_RESULT-1 -: DBIT];
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_overrun  = ovr_q;

endmodule
